spi_master_tx_shifter: RTL and testbench

Byte-serial SPI master transmit engine that sits directly downstream of the master TX FIFO in the SPI peripheral. It pops bytes from a valid/ready FIFO read port, frames them with chip-select setup and hold, and shifts them out MSB-first on MOSI with a divided SCK in any of the four CPOL/CPHA modes. Bytes already waiting at the end of a byte are sent back-to-back inside the same CS frame with no SCK gap.

---
 rtl/spi_master_tx_shifter.sv | 138 +++++++++++++
 tb/tb_spi_master_tx_shifter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_tx_shifter.sv
// SPI master transmit engine: pops bytes from a valid/ready FIFO read port, frames them with
// CS setup/hold and shifts them out MSB-first with a divided SCK in any CPOL/CPHA mode.
// Bytes already waiting at the end of a byte continue in the same CS frame with no SCK gap.
module spi_master_tx_shifter #(
  parameter int unsigned ClkDiv  = 4,    // clk_i cycles per SCK half-period, >= 1
  parameter int unsigned CsSetup = 2,    // CS-low cycles before the first half-period, >= 1
  parameter int unsigned CsHold  = 2,    // CS-low cycles after the last half-period, >= 1
  parameter bit          CPOL    = 1'b0, // SCK idle level
  parameter bit          CPHA    = 1'b0  // 0: sample on leading edge, 1: on trailing edge
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_pop_o,
  output logic       spi_sck_o,
  output logic       spi_mosi_o,
  output logic       spi_cs_o,
  output logic       busy_o
);

  localparam int unsigned DivW   = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam int unsigned CntMax = (CsSetup > CsHold) ? CsSetup : CsHold;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [DivW-1:0] DivLast   = DivW'(ClkDiv - 1);
  localparam logic [CntW-1:0] SetupLast = CntW'(CsSetup - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(CsHold - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

  state_e          state_q;
  logic [7:0]      shreg_q;
  logic [3:0]      half_q;
  logic [DivW-1:0] div_q;
  logic [CntW-1:0] cnt_q;
  logic            sck_q;
  logic            mosi_q;
  logic            cs_q;
  logic            busy_q;

  logic            half_end;
  logic            last_half;
  logic            shift_edge;

  assign half_end  = (div_q == DivLast);
  assign last_half = half_end && (half_q == 4'd15);

  // Even halves end on a leading edge, odd halves on a trailing edge. Data moves on the edge
  // opposite to the sampling edge, skipping the very first (CPHA=1) or very last (CPHA=0) one.
  assign shift_edge = CPHA ? (!half_q[0] && (half_q != 4'd0))
                           : ( half_q[0] && (half_q != 4'd15));

  // The pop is combinational so the FIFO head is captured in the same cycle it is acknowledged.
  assign tx_pop_o = tx_valid_i && ((state_q == StIdle) || ((state_q == StShift) && last_half));

  assign spi_sck_o  = sck_q;
  assign spi_mosi_o = mosi_q;
  assign spi_cs_o   = cs_q;
  assign busy_o     = busy_q;

  // Framing FSM with counters and registered line outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      shreg_q <= 8'h00;
      half_q  <= 4'd0;
      div_q   <= '0;
      cnt_q   <= '0;
      sck_q   <= CPOL;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (tx_valid_i) begin
            state_q <= StSetup;
            shreg_q <= tx_data_i;
            mosi_q  <= tx_data_i[7];
            cs_q    <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        StSetup: begin
          if (cnt_q == SetupLast) begin
            state_q <= StShift;
            cnt_q   <= '0;
            half_q  <= 4'd0;
            div_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StShift: begin
          if (half_end) begin
            div_q <= '0;
            sck_q <= ~sck_q;
            if (half_q == 4'd15) begin
              if (tx_valid_i) begin
                // Back-to-back byte: same frame, SCK cadence unbroken.
                shreg_q <= tx_data_i;
                mosi_q  <= tx_data_i[7];
                half_q  <= 4'd0;
              end else begin
                state_q <= StHold;
                cnt_q   <= '0;
              end
            end else begin
              half_q <= half_q + 4'd1;
              if (shift_edge) begin
                shreg_q <= {shreg_q[6:0], 1'b0};
                mosi_q  <= shreg_q[6];
              end
            end
          end else begin
            div_q <= div_q + DivW'(1);
          end
        end
        StHold: begin
          if (cnt_q == HoldLast) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cs_q    <= 1'b1;
            sck_q   <= CPOL;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_tx_shifter.sv
// Directed bench for spi_master_tx_shifter: three instances cover mode 0 defaults,
// CPOL=1/CPHA=1, and the minimum ClkDiv/CsSetup/CsHold configuration.
module tb_spi_master_tx_shifter;

  logic       clk;
  logic       rst_n;
  logic       valid_v [3];
  logic [7:0] data_v  [3];
  logic       pop_w   [3];
  logic       sck_w   [3];
  logic       mosi_w  [3];
  logic       cs_w    [3];
  logic       busy_w  [3];

  // Per-cycle record of the instance under test; index 0 is the first cycle of a run.
  logic sck_r  [256];
  logic mosi_r [256];
  logic cs_r   [256];
  logic pop_r  [256];
  logic busy_r [256];
  int   rise_at [16];

  logic [7:0] q [$];
  int         mask_lo = -1;
  int         mask_hi = -1;
  int         checks  = 0;
  int         errors  = 0;

  spi_master_tx_shifter u_dut0 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .tx_valid_i (valid_v[0]),
    .tx_data_i  (data_v[0]),
    .tx_pop_o   (pop_w[0]),
    .spi_sck_o  (sck_w[0]),
    .spi_mosi_o (mosi_w[0]),
    .spi_cs_o   (cs_w[0]),
    .busy_o     (busy_w[0])
  );

  spi_master_tx_shifter #(
    .CPOL (1'b1),
    .CPHA (1'b1)
  ) u_dut1 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .tx_valid_i (valid_v[1]),
    .tx_data_i  (data_v[1]),
    .tx_pop_o   (pop_w[1]),
    .spi_sck_o  (sck_w[1]),
    .spi_mosi_o (mosi_w[1]),
    .spi_cs_o   (cs_w[1]),
    .busy_o     (busy_w[1])
  );

  spi_master_tx_shifter #(
    .ClkDiv  (1),
    .CsSetup (1),
    .CsHold  (1)
  ) u_dut2 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .tx_valid_i (valid_v[2]),
    .tx_data_i  (data_v[2]),
    .tx_pop_o   (pop_w[2]),
    .spi_sck_o  (sck_w[2]),
    .spi_mosi_o (mosi_w[2]),
    .spi_cs_o   (cs_w[2]),
    .busy_o     (busy_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO read-port model: valid while the queue is non-empty, unless masked for this cycle.
  task automatic drive(input int d, input int k);
    valid_v[d] = (q.size() > 0) && !((k >= mask_lo) && (k <= mask_hi));
    data_v[d]  = (q.size() > 0) ? q[0] : 8'h00;
  endtask

  task automatic run(input int d, input int n);
    @(posedge clk); #1;
    drive(d, 0);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      sck_r[k]  = sck_w[d];
      mosi_r[k] = mosi_w[d];
      cs_r[k]   = cs_w[d];
      pop_r[k]  = pop_w[d];
      busy_r[k] = busy_w[d];
      @(posedge clk); #1;
      if (pop_r[k]) void'(q.pop_front());
      drive(d, k + 1);
    end
    valid_v[d] = 1'b0;
  endtask

  // Collect MOSI as seen just before every rising SCK edge in [lo, hi].
  task automatic decode(input int lo, input int hi, output int nrise, output logic [15:0] bits);
    nrise = 0;
    bits  = '0;
    for (int k = lo; k <= hi; k++) begin
      if (k > 0 && sck_r[k] && !sck_r[k-1]) begin
        if (nrise < 16) rise_at[nrise] = k;
        nrise++;
        bits = {bits[14:0], mosi_r[k-1]};
      end
    end
  endtask

  function automatic int count_pop(input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++) n += int'(pop_r[k]);
    return n;
  endfunction

  function automatic int count_cs_low(input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++) n += int'(!cs_r[k]);
    return n;
  endfunction

  initial begin
    int          nr;
    int          n;
    logic [15:0] bits;

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      valid_v[d] = 1'b0;
      data_v[d]  = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_cs", {31'd0, cs_w[0]}, 1);
    check_eq("rst_sck_cpol0", {31'd0, sck_w[0]}, 0);
    check_eq("rst_sck_cpol1", {31'd0, sck_w[1]}, 1);
    check_eq("rst_mosi", {31'd0, mosi_w[0]}, 0);
    check_eq("rst_busy", {31'd0, busy_w[0]}, 0);
    check_eq("rst_pop", {31'd0, pop_w[0]}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mode 0 defaults, single byte 0xA5.
    q = {8'hA5};
    run(0, 80);
    check_eq("t1_pop_count", count_pop(0, 79), 1);
    check_eq("t1_pop_at_0", {31'd0, pop_r[0]}, 1);
    check_eq("t1_cs_high_0", {31'd0, cs_r[0]}, 1);
    check_eq("t1_cs_low_1_68", count_cs_low(1, 68), 68);
    check_eq("t1_cs_high_69", {31'd0, cs_r[69]}, 1);
    check_eq("t1_busy_1", {31'd0, busy_r[1]}, 1);
    check_eq("t1_busy_69", {31'd0, busy_r[69]}, 0);
    decode(1, 79, nr, bits);
    check_eq("t1_rise_count", nr, 8);
    check_eq("t1_first_rise", rise_at[0], 7);
    check_eq("t1_byte", {24'd0, bits[7:0]}, 32'hA5);

    // Two bytes waiting: one frame, second byte popped on the last cycle of byte one.
    q = {8'h3C, 8'hC3};
    run(0, 150);
    check_eq("t2_pop_count", count_pop(0, 149), 2);
    check_eq("t2_pop_at_0", {31'd0, pop_r[0]}, 1);
    check_eq("t2_pop_at_66", {31'd0, pop_r[66]}, 1);
    check_eq("t2_cs_low_1_132", count_cs_low(1, 132), 132);
    check_eq("t2_cs_high_133", {31'd0, cs_r[133]}, 1);
    decode(1, 149, nr, bits);
    check_eq("t2_rise_count", nr, 16);
    n = 0;
    for (int i = 1; i < 16; i++) n += int'(rise_at[i] - rise_at[i-1] == 8);
    check_eq("t2_uniform_gaps", n, 15);
    check_eq("t2_bytes", {16'd0, bits}, 32'h3CC3);

    // CPOL=1, CPHA=1: rising edges are trailing edges.
    q = {8'h81};
    run(1, 80);
    check_eq("t3_sck_idle_high", {31'd0, sck_r[0]}, 1);
    decode(1, 79, nr, bits);
    check_eq("t3_rise_count", nr, 8);
    check_eq("t3_byte", {24'd0, bits[7:0]}, 32'h81);
    check_eq("t3_cs_high_69", {31'd0, cs_r[69]}, 1);
    check_eq("t3_sck_at_cs_rise", {31'd0, sck_r[69]}, 1);
    check_eq("t3_sck_before_cs_rise", {31'd0, sck_r[68]}, 1);

    // Reset in the middle of a 0xFF byte.
    q = {8'hFF};
    run(0, 30);
    check_eq("t4_cs_low_29", {31'd0, cs_r[29]}, 0);
    check_eq("t4_mosi_29", {31'd0, mosi_r[29]}, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("t4_rst_cs", {31'd0, cs_w[0]}, 1);
    check_eq("t4_rst_sck", {31'd0, sck_w[0]}, 0);
    check_eq("t4_rst_mosi", {31'd0, mosi_w[0]}, 0);
    check_eq("t4_rst_busy", {31'd0, busy_w[0]}, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 40);
    check_eq("t4_no_pop", count_pop(0, 39), 0);
    check_eq("t4_cs_stays_high", count_cs_low(0, 39), 0);

    // ClkDiv=1, CsSetup=1, CsHold=1, byte 0x01.
    q = {8'h01};
    run(2, 30);
    check_eq("t5_cs_low_1_18", count_cs_low(1, 18), 18);
    check_eq("t5_cs_low_total", count_cs_low(0, 29), 18);
    n = 0;
    for (int k = 3; k <= 18; k++) n += int'(sck_r[k] != sck_r[k-1]);
    check_eq("t5_toggle_every_cycle", n, 16);
    decode(1, 29, nr, bits);
    check_eq("t5_rise_count", nr, 8);
    check_eq("t5_last_bit", {31'd0, bits[0]}, 1);
    check_eq("t5_byte", {24'd0, bits[7:0]}, 32'h01);

    // Valid drops across the end of half 15: HOLD, IDLE, then a new frame after 1 CS-high cycle.
    q = {8'h5A, 8'h96};
    mask_lo = 66;
    mask_hi = 68;
    run(0, 150);
    mask_lo = -1;
    mask_hi = -1;
    check_eq("t6_no_pop_66", {31'd0, pop_r[66]}, 0);
    check_eq("t6_hold_cs_68", {31'd0, cs_r[68]}, 0);
    check_eq("t6_gap_cs_69", {31'd0, cs_r[69]}, 1);
    check_eq("t6_pop_69", {31'd0, pop_r[69]}, 1);
    check_eq("t6_cs_low_70", {31'd0, cs_r[70]}, 0);
    check_eq("t6_pop_count", count_pop(0, 149), 2);
    decode(70, 149, nr, bits);
    check_eq("t6_second_byte", {24'd0, bits[7:0]}, 32'h96);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
